// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// datapath select encodings and the ALU-op class passed to the ALU decoder.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADR  = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_LUI      = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JAL      = 4'd12,
    S_HALT     = 4'd13,
    S_ERROR    = 4'd14
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'd0,
    ALUOP_SUB  = 2'd1,
    ALUOP_FUNC = 2'd2,
    ALUOP_LUI  = 2'd3
  } alu_op_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format follows the opcode alone, independent of FSM state.
  function automatic logic [2:0] imm_src_decode(input logic [6:0] op);
    logic [2:0] imm;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_B:    imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      OP_LUI:  imm = IMM_U;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's ALU-op class and the
// instruction function fields.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] alu_control
);

  logic is_sub_s;

  // func7 only distinguishes sub from add for register-register ops.
  always_comb begin
    is_sub_s    = (op == OP_R) && (func7 == 7'b0100000);
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_LUI: alu_control = ALU_PASSB;
      ALUOP_FUNC: begin
        case (func3)
          3'b000:  alu_control = is_sub_s ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b100:  alu_control = ALU_XOR;
          3'b010:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller_mc.sv
// Multi-cycle RV32I Moore controller with req/ready memory handshake,
// access timeout fault and retired-instruction counter.
module controller_mc
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             Zero,
  input  logic             lt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [2:0]       ImmSrc,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] CNT_LIMIT = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s, pc_write_s, reg_write_s;
  logic [1:0] result_src_s, src_a_s, src_b_s;
  logic [2:0] alu_control_s;
  logic       done_s, err_s, at_limit_s, taken_s;
  alu_op_e    alu_op_s;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .op          (op),
    .func3       (func3),
    .func7       (func7),
    .alu_control (alu_control_s)
  );

  // State, timeout counter and retired count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end

  // Branch condition from func3 and ALU flags.
  always_comb begin
    case (func3)
      3'b000:  taken_s = Zero;
      3'b001:  taken_s = ~Zero;
      3'b100:  taken_s = lt;
      3'b101:  taken_s = ~lt;
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_d      = state_q;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = RES_ALUOUT;
    src_a_s      = SRCA_PC;
    src_b_s      = SRCB_B;
    alu_op_s     = ALUOP_ADD;
    done_s       = 1'b0;
    err_s        = 1'b0;
    at_limit_s   = (cnt_q == CNT_LIMIT);
    case (state_q)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        src_b_s      = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
        if (mem_ready)       state_d = S_DECODE;
        else if (at_limit_s) state_d = S_ERROR;
        else                 state_d = S_FETCH;
      end
      S_DECODE: begin
        src_a_s = SRCA_OLDPC;
        src_b_s = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR_ADR;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEM_ADR: begin
        src_a_s = SRCA_A;
        src_b_s = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem_ready)       state_d = S_MEM_WB;
        else if (at_limit_s) state_d = S_ERROR;
        else                 state_d = S_MEM_RD;
      end
      S_MEM_WB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src_s   = 1'b1;
        if (mem_ready)       state_d = S_FETCH;
        else if (at_limit_s) state_d = S_ERROR;
        else                 state_d = S_MEM_WR;
      end
      S_EXEC_R: begin
        src_a_s  = SRCA_A;
        src_b_s  = SRCB_B;
        alu_op_s = ALUOP_FUNC;
        state_d  = S_ALU_WB;
      end
      S_EXEC_I: begin
        src_a_s  = SRCA_A;
        src_b_s  = SRCB_IMM;
        alu_op_s = ALUOP_FUNC;
        state_d  = S_ALU_WB;
      end
      S_LUI: begin
        src_b_s  = SRCB_IMM;
        alu_op_s = ALUOP_LUI;
        state_d  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_s    = SRCA_A;
        src_b_s    = SRCB_B;
        alu_op_s   = ALUOP_SUB;
        pc_write_s = taken_s;
        state_d    = S_FETCH;
      end
      S_JALR_ADR: begin
        src_a_s = SRCA_A;
        src_b_s = SRCB_IMM;
        state_d = S_JAL;
      end
      S_JAL: begin
        // ALUOut holds the target; OldPC+4 is computed for the link write.
        src_a_s    = SRCA_OLDPC;
        src_b_s    = SRCB_FOUR;
        pc_write_s = 1'b1;
        state_d    = S_ALU_WB;
      end
      S_HALT: begin
        done_s  = 1'b1;
        state_d = S_HALT;
      end
      S_ERROR: begin
        err_s   = 1'b1;
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Timeout counter restarts on every state change and counts stalled requests.
  always_comb begin
    if (state_d != state_q)           cnt_d = '0;
    else if (mem_req_s && !mem_ready) cnt_d = cnt_q + TW'(1);
    else                              cnt_d = cnt_q;
  end

  // Retire on any return to FETCH; HALT/ERROR never return without reset.
  always_comb begin
    if (state_d == S_FETCH && state_q != S_FETCH) instret_d = instret_q + CNT_W'(1);
    else                                          instret_d = instret_q;
  end

  // Reset forces outputs low combinationally so a pending request drops at once.
  always_comb begin
    ImmSrc  = imm_src_decode(op);
    instret = instret_q;
    if (!rst) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
      done       = 1'b0;
      err        = 1'b0;
    end else begin
      mem_req    = mem_req_s;
      MemWrite   = mem_write_s;
      AdrSrc     = adr_src_s;
      IRWrite    = ir_write_s;
      PCWrite    = pc_write_s;
      RegWrite   = reg_write_s;
      ResultSrc  = result_src_s;
      ALUSrcA    = src_a_s;
      ALUSrcB    = src_b_s;
      ALUControl = alu_control_s;
      done       = done_s;
      err        = err_s;
    end
  end

endmodule

// File: tb/tb_controller_mc.sv
// Directed scoreboard bench for controller_mc: per-cycle expected output
// vectors are queued with the stimulus and checked once the DUT presents them.
module tb_controller_mc;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        Zero;
  logic        lt;
  logic        mem_ready;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ALUControl, ImmSrc;
  logic        done, err;
  logic [31:0] instret;

  int checks;
  int failures;

  typedef struct {
    string       tag;
    logic [19:0] vec;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];

  controller_mc #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .func3      (func3),
    .func7      (func7),
    .Zero       (Zero),
    .lt         (lt),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .done       (done),
    .err        (err),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [19:0] obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, done, err};

  function automatic logic [19:0] mk(input logic req, input logic mw, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] ac,
                                     input logic [2:0] is, input logic dn, input logic er);
    return {req, mw, adr, irw, pcw, rw, rs, sa, sb, ac, is, dn, er};
  endfunction

  function automatic logic [19:0] v_fetch(input logic rdy, input logic [2:0] is);
    return mk(1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, is, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] v_dec(input logic [2:0] is);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, is, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] v_wb(input logic [2:0] is);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, is, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] v_memadr(input logic [2:0] is);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, is, 1'b0, 1'b0);
  endfunction

  task automatic expect_cyc(input string tag, input logic [19:0] vec, input logic [31:0] inst);
    exp_t e;
    e.tag  = tag;
    e.vec  = vec;
    e.inst = inst;
    sb_q.push_back(e);
  endtask

  task automatic check_head();
    exp_t e;
    #1;
    checks++;
    assert (sb_q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      assert (obs === e.vec) else begin
        failures++;
        $error("FAIL %s outputs observed=%b expected=%b", e.tag, obs, e.vec);
      end
      checks++;
      assert (instret === e.inst) else begin
        failures++;
        $error("FAIL %s instret observed=%0d expected=%0d", e.tag, instret, e.inst);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check_head();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op    = o;
    func3 = f3;
    func7 = f7;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    Zero      = 1'b0;
    lt        = 1'b0;
    mem_ready = 1'b1;
    set_ir(7'b0100011, 3'b010, 7'b0000000);

    // Reset: everything low except the opcode-driven ImmSrc (sw -> S type).
    #2;
    expect_cyc("reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                           3'b000, 3'b001, 1'b0, 1'b0), 32'd0);
    check_head();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // add x3,x1,x2
    set_ir(7'b0110011, 3'b000, 7'b0000000);
    expect_cyc("add_fetch", v_fetch(1'b1, 3'b000), 32'd0);
    expect_cyc("add_decode", v_dec(3'b000), 32'd0);
    expect_cyc("add_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00,
                              3'b000, 3'b000, 1'b0, 1'b0), 32'd0);
    expect_cyc("add_wb", v_wb(3'b000), 32'd0);
    run(4);

    // sub
    set_ir(7'b0110011, 3'b000, 7'b0100000);
    expect_cyc("sub_fetch", v_fetch(1'b1, 3'b000), 32'd1);
    expect_cyc("sub_decode", v_dec(3'b000), 32'd1);
    expect_cyc("sub_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00,
                              3'b001, 3'b000, 1'b0, 1'b0), 32'd1);
    expect_cyc("sub_wb", v_wb(3'b000), 32'd1);
    run(4);

    // xori
    set_ir(7'b0010011, 3'b100, 7'b0100000);
    expect_cyc("xori_fetch", v_fetch(1'b1, 3'b000), 32'd2);
    expect_cyc("xori_decode", v_dec(3'b000), 32'd2);
    expect_cyc("xori_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01,
                               3'b111, 3'b000, 1'b0, 1'b0), 32'd2);
    expect_cyc("xori_wb", v_wb(3'b000), 32'd2);
    run(4);

    // lw with three wait cycles; ready arrives as the count hits the limit
    set_ir(7'b0000011, 3'b010, 7'b0000000);
    expect_cyc("lw_fetch", v_fetch(1'b1, 3'b000), 32'd3);
    expect_cyc("lw_decode", v_dec(3'b000), 32'd3);
    expect_cyc("lw_memadr", v_memadr(3'b000), 32'd3);
    run(3);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_cyc("lw_memrd_wait", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                                     3'b000, 3'b000, 1'b0, 1'b0), 32'd3);
      run(1);
    end
    mem_ready = 1'b1;
    expect_cyc("lw_memrd_ready", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                                    3'b000, 3'b000, 1'b0, 1'b0), 32'd3);
    expect_cyc("lw_memwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00,
                              3'b000, 3'b000, 1'b0, 1'b0), 32'd3);
    run(2);

    // bne, not equal -> taken
    set_ir(7'b1100011, 3'b001, 7'b0000000);
    Zero = 1'b0;
    expect_cyc("bne_fetch", v_fetch(1'b1, 3'b010), 32'd4);
    expect_cyc("bne_decode", v_dec(3'b010), 32'd4);
    expect_cyc("bne_branch", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00,
                                3'b001, 3'b010, 1'b0, 1'b0), 32'd4);
    run(3);

    // bge with lt -> not taken
    set_ir(7'b1100011, 3'b101, 7'b0000000);
    lt = 1'b1;
    expect_cyc("bge_fetch", v_fetch(1'b1, 3'b010), 32'd5);
    expect_cyc("bge_decode", v_dec(3'b010), 32'd5);
    expect_cyc("bge_branch", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00,
                                3'b001, 3'b010, 1'b0, 1'b0), 32'd5);
    run(3);
    lt = 1'b0;

    // sw
    set_ir(7'b0100011, 3'b010, 7'b0000000);
    expect_cyc("sw_fetch", v_fetch(1'b1, 3'b001), 32'd6);
    expect_cyc("sw_decode", v_dec(3'b001), 32'd6);
    expect_cyc("sw_memadr", v_memadr(3'b001), 32'd6);
    expect_cyc("sw_memwr", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                              3'b000, 3'b001, 1'b0, 1'b0), 32'd6);
    run(4);

    // jalr
    set_ir(7'b1100111, 3'b000, 7'b0000000);
    expect_cyc("jalr_fetch", v_fetch(1'b1, 3'b000), 32'd7);
    expect_cyc("jalr_decode", v_dec(3'b000), 32'd7);
    expect_cyc("jalr_adr", v_memadr(3'b000), 32'd7);
    expect_cyc("jalr_jal", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10,
                              3'b000, 3'b000, 1'b0, 1'b0), 32'd7);
    expect_cyc("jalr_wb", v_wb(3'b000), 32'd7);
    run(5);

    // lui
    set_ir(7'b0110111, 3'b000, 7'b0000000);
    expect_cyc("lui_fetch", v_fetch(1'b1, 3'b100), 32'd8);
    expect_cyc("lui_decode", v_dec(3'b100), 32'd8);
    expect_cyc("lui_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01,
                              3'b100, 3'b100, 1'b0, 1'b0), 32'd8);
    expect_cyc("lui_wb", v_wb(3'b100), 32'd8);
    run(4);

    // Fetch timeout: four stalled cycles then ERROR
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_cyc("to_fetch_wait", v_fetch(1'b0, 3'b100), 32'd9);
    expect_cyc("to_error", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                              3'b000, 3'b100, 1'b0, 1'b1), 32'd9);
    run(5);
    mem_ready = 1'b1;
    expect_cyc("error_held", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                                3'b000, 3'b100, 1'b0, 1'b1), 32'd9);
    check_head();
    // Asynchronous reset between edges
    rst = 1'b0;
    expect_cyc("async_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                                 3'b000, 3'b100, 1'b0, 1'b0), 32'd0);
    check_head();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Unsupported opcode halts; mem_ready is ignored there
    set_ir(7'b0000000, 3'b000, 7'b0000000);
    expect_cyc("halt_fetch", v_fetch(1'b1, 3'b000), 32'd0);
    expect_cyc("halt_decode", v_dec(3'b000), 32'd0);
    for (int i = 0; i < 3; i++)
      expect_cyc("halt_held", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                                 3'b000, 3'b000, 1'b1, 1'b0), 32'd0);
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
